secventiator_faze: RTL and testbench
====================================

SECVENTIATOR_FAZE -- requirements
Module: secventiator_faze

Interface
REQ-001 SHALL have parameter N_DIR, default 4, meaning number of directional phases cycled (legal 2..4).
REQ-002 SHALL have parameter T_MAX, default 200, meaning watchdog limit in clk_div ticks without ready_S (legal 1..65535).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port clk_div  input  1  meaning one-clk-wide tick enable for the watchdog.
REQ-006 SHALL have port ready_S  input  1  meaning one-clk pulse, current phase finished.
REQ-007 SHALL have port cerere_pietoni  input  1  meaning one-clk pedestrian request pulse.
REQ-008 SHALL have port mod_service  input  1  meaning level, forces SERVICE while high.
REQ-009 SHALL have port stare_semafor  output  3  meaning current phase code, registered.
REQ-010 SHALL have port schimbare  output  1  meaning one-clk pulse in the cycle stare_semafor takes a new value.
REQ-011 SHALL have port eroare  output  1  meaning sticky watchdog fault flag.

Function
REQ-012 SHALL use phase codes SUD=000, EST=001, VEST=010, NORD=011, PIETONI=100, SERVICE=111; codes 101/110 never driven.
REQ-013 SHALL cycle directional phases 0 -> 1 -> ... -> N_DIR-1 -> 0, one step per ready_S, stare_semafor updating the clock edge after ready_S (latency 1).
REQ-014 SHALL latch cerere_pietoni into a pending flag; ready_S in a directional phase with flag set (including flag set in the same cycle) goes to PIETONI instead of the next direction.
REQ-015 SHALL clear the pending flag on entry to PIETONI; requests arriving while in PIETONI are dropped.
REQ-016 SHALL, on ready_S in PIETONI, go to the directional phase following the one that preceded PIETONI (wrap at N_DIR-1 -> 0).
REQ-017 SHALL enter SERVICE on the edge after mod_service is sampled high, from any phase, with priority over ready_S and pending requests; pending flag preserved.
REQ-018 SHALL ignore ready_S while in SERVICE; on mod_service sampled low (and eroare low) SHALL go to SUD next edge.
REQ-019 SHALL count clk_div ticks in a watchdog counter of width clog2(T_MAX+1), cleared on every change of stare_semafor and held at 0 in SERVICE.
REQ-020 SHALL, when the counter reaches T_MAX with no ready_S in that cycle, enter SERVICE and set eroare on the same edge.
REQ-021 SHALL keep eroare high and stare_semafor at SERVICE until rst, regardless of mod_service or ready_S.
REQ-022 SHALL give ready_S priority over the watchdog when both occur in the same cycle (normal advance, counter cleared).
REQ-023 SHALL pulse schimbare exactly once per transition, never when the phase is unchanged (e.g. mod_service held high in SERVICE).

Reset
REQ-024 SHALL, while rst high, asynchronously force stare_semafor=SUD, schimbare=0, eroare=0, pending flag=0, watchdog counter=0.
REQ-025 SHALL, on rst deassertion mid-operation, resume from SUD with no memory of prior phase or requests; first schimbare only on the first subsequent transition.

Verification
REQ-026 SHALL cover: N_DIR=4, four ready_S pulses after reset -> stare_semafor 001,010,011,000, schimbare 4 pulses.
REQ-027 SHALL cover: N_DIR=3, in VEST pulse cerere_pietoni, then ready_S twice -> 100 then 000; pending flag clear.
REQ-028 SHALL cover: cerere_pietoni and ready_S same cycle in SUD -> 100, then ready_S -> 001.
REQ-029 SHALL cover: mod_service high in EST with simultaneous ready_S -> 111 next edge; mod_service low -> 000 next edge.
REQ-030 SHALL cover: T_MAX=5, clk_div every cycle, no ready_S -> 111 and eroare=1 after 5th tick; mod_service toggling and ready_S leave it unchanged; rst -> 000, eroare=0.
REQ-031 SHALL cover: rst asserted mid-cycle in PIETONI with pending request -> immediate 000, no PIETONI after release until a new request.

Source files
------------

// File: rtl/secventiator_faze.sv
// secventiator_faze: traffic-light phase sequencer.
// Cycles N_DIR directional phases on ready_S, inserts a pedestrian phase on
// request, forces a SERVICE phase on mod_service, and latches a sticky fault
// when a phase overstays T_MAX clk_div ticks.
module secventiator_faze #(
    parameter int N_DIR = 4,
    parameter int T_MAX = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_div,
    input  logic       ready_S,
    input  logic       cerere_pietoni,
    input  logic       mod_service,
    output logic [2:0] stare_semafor,
    output logic       schimbare,
    output logic       eroare
);

    typedef enum logic [2:0] {
        SUD     = 3'b000,
        EST     = 3'b001,
        VEST    = 3'b010,
        NORD    = 3'b011,
        PIETONI = 3'b100,
        SERVICE = 3'b111
    } faza_t;

    localparam int              CW       = $clog2(T_MAX + 1);
    // The fault fires on the tick that would bring the counter to T_MAX.
    localparam logic [CW-1:0]   WD_LAST  = CW'(T_MAX - 1);
    localparam logic [2:0]      DIR_LAST = 3'(N_DIR - 1);

    faza_t         stare_q, stare_d;
    faza_t         dir_prev_q, dir_prev_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] wd_q, wd_d;
    logic          err_d;
    logic          wd_hit;
    logic          in_dir;

    // Successor of a directional phase, wrapping after the last configured one.
    function automatic faza_t urmatoarea_dir(input faza_t f);
        logic [2:0] cod;
        faza_t      rez;
        cod = f;
        if (cod >= DIR_LAST) begin
            rez = SUD;
        end else begin
            rez = faza_t'(cod + 3'd1);
        end
        return rez;
    endfunction

    // Classify the current phase and detect a watchdog expiry this cycle.
    always_comb begin
        in_dir = (stare_q != PIETONI) && (stare_q != SERVICE);
        wd_hit = clk_div && (wd_q == WD_LAST) && !ready_S && (stare_q != SERVICE);
    end

    // Next phase: fault lock, then service/watchdog, then normal sequencing.
    always_comb begin
        stare_d    = stare_q;
        dir_prev_d = dir_prev_q;
        err_d      = eroare;
        if (eroare) begin
            stare_d = SERVICE;
        end else if (mod_service || wd_hit) begin
            stare_d = SERVICE;
            err_d   = wd_hit;
        end else begin
            case (stare_q)
                SERVICE: begin
                    stare_d = SUD;
                end
                PIETONI: begin
                    if (ready_S) begin
                        stare_d = urmatoarea_dir(dir_prev_q);
                    end
                end
                default: begin
                    if (ready_S) begin
                        if (pend_q || cerere_pietoni) begin
                            stare_d    = PIETONI;
                            dir_prev_d = stare_q;
                        end else begin
                            stare_d = urmatoarea_dir(stare_q);
                        end
                    end
                end
            endcase
        end
    end

    // Pedestrian request flag: cleared on entry to PIETONI, deaf while in it.
    always_comb begin
        pend_d = pend_q;
        if ((stare_d == PIETONI) && (stare_q != PIETONI)) begin
            pend_d = 1'b0;
        end else if (cerere_pietoni && (stare_q != PIETONI)) begin
            pend_d = 1'b1;
        end
    end

    // Watchdog count: restarts on every phase change, parked at zero in SERVICE.
    always_comb begin
        wd_d = wd_q;
        if ((stare_d != stare_q) || (stare_q == SERVICE)) begin
            wd_d = '0;
        end else if (clk_div && in_dir) begin
            wd_d = wd_q + CW'(1);
        end else if (clk_div) begin
            wd_d = wd_q + CW'(1);
        end
    end

    // State, flags and the registered change strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stare_q    <= SUD;
            dir_prev_q <= SUD;
            pend_q     <= 1'b0;
            wd_q       <= '0;
            eroare     <= 1'b0;
            schimbare  <= 1'b0;
        end else begin
            stare_q    <= stare_d;
            dir_prev_q <= dir_prev_d;
            pend_q     <= pend_d;
            wd_q       <= wd_d;
            eroare     <= err_d;
            schimbare  <= (stare_d != stare_q);
        end
    end

    assign stare_semafor = stare_q;

endmodule

// File: tb/tb_secventiator_faze.sv
// Directed bench for secventiator_faze: three instances cover N_DIR=4,
// N_DIR=3 and a short watchdog (T_MAX=5) from shared stimulus.
module tb_secventiator_faze;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_div;
    logic       ready_S;
    logic       cerere_pietoni;
    logic       mod_service;
    logic [2:0] st4, st3, stw;
    logic       sc4, sc3, scw;
    logic       er4, er3, erw;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    secventiator_faze #(.N_DIR(4), .T_MAX(200)) u4 (
        .clk(clk), .rst(rst), .clk_div(clk_div), .ready_S(ready_S),
        .cerere_pietoni(cerere_pietoni), .mod_service(mod_service),
        .stare_semafor(st4), .schimbare(sc4), .eroare(er4));

    secventiator_faze #(.N_DIR(3), .T_MAX(200)) u3 (
        .clk(clk), .rst(rst), .clk_div(clk_div), .ready_S(ready_S),
        .cerere_pietoni(cerere_pietoni), .mod_service(mod_service),
        .stare_semafor(st3), .schimbare(sc3), .eroare(er3));

    secventiator_faze #(.N_DIR(4), .T_MAX(5)) uw (
        .clk(clk), .rst(rst), .clk_div(clk_div), .ready_S(ready_S),
        .cerere_pietoni(cerere_pietoni), .mod_service(mod_service),
        .stare_semafor(stw), .schimbare(scw), .eroare(erw));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        ready_S = 1'b0; cerere_pietoni = 1'b0; mod_service = 1'b0; clk_div = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_ready();
        ready_S = 1'b1;
        step();
        ready_S = 1'b0;
    endtask

    task automatic test_reset();
        ready_S = 1'b0; cerere_pietoni = 1'b0; mod_service = 1'b0; clk_div = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (st4 !== 3'b000) begin errors++; $display("FAIL reset_stare got=%b exp=000", st4); end
        checks++; if (sc4 !== 1'b0) begin errors++; $display("FAIL reset_schimbare got=%b exp=0", sc4); end
        checks++; if (er4 !== 1'b0) begin errors++; $display("FAIL reset_eroare got=%b exp=0", er4); end
        step();
        rst = 1'b0;
        step();
        step();
        checks++; if (st4 !== 3'b000 || sc4 !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b/%b exp=000/0", st4, sc4); end
    endtask

    task automatic test_cycle4();
        logic [2:0] exp_seq [4];
        exp_seq = '{3'b001, 3'b010, 3'b011, 3'b000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            pulse_ready();
            checks++; if (st4 !== exp_seq[i]) begin errors++; $display("FAIL cycle4_stare[%0d] got=%b exp=%b", i, st4, exp_seq[i]); end
            checks++; if (sc4 !== 1'b1) begin errors++; $display("FAIL cycle4_puls[%0d] got=%b exp=1", i, sc4); end
            step();
            checks++; if (sc4 !== 1'b0) begin errors++; $display("FAIL cycle4_idle[%0d] got=%b exp=0", i, sc4); end
        end
        checks++; if (st3 !== 3'b001) begin errors++; $display("FAIL cycle3_wrap got=%b exp=001", st3); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_seq [3];
        exp_seq = '{3'b001, 3'b010, 3'b011};
        apply_reset();
        ready_S = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (st4 !== exp_seq[i] || sc4 !== 1'b1) begin errors++; $display("FAIL b2b[%0d] got=%b/%b exp=%b/1", i, st4, sc4, exp_seq[i]); end
        end
        ready_S = 1'b0;
        step();
        checks++; if (st4 !== 3'b011 || sc4 !== 1'b0) begin errors++; $display("FAIL b2b_hold got=%b/%b exp=011/0", st4, sc4); end
    endtask

    task automatic test_pietoni_n3();
        apply_reset();
        pulse_ready();
        pulse_ready();
        checks++; if (st3 !== 3'b010) begin errors++; $display("FAIL n3_vest got=%b exp=010", st3); end
        cerere_pietoni = 1'b1;
        step();
        cerere_pietoni = 1'b0;
        checks++; if (st3 !== 3'b010 || sc3 !== 1'b0) begin errors++; $display("FAIL n3_req_hold got=%b/%b exp=010/0", st3, sc3); end
        pulse_ready();
        checks++; if (st3 !== 3'b100 || sc3 !== 1'b1) begin errors++; $display("FAIL n3_pietoni got=%b/%b exp=100/1", st3, sc3); end
        pulse_ready();
        checks++; if (st3 !== 3'b000) begin errors++; $display("FAIL n3_wrap got=%b exp=000", st3); end
        pulse_ready();
        checks++; if (st3 !== 3'b001) begin errors++; $display("FAIL n3_flag_clear got=%b exp=001", st3); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        cerere_pietoni = 1'b1;
        ready_S = 1'b1;
        step();
        cerere_pietoni = 1'b0;
        ready_S = 1'b0;
        checks++; if (st4 !== 3'b100) begin errors++; $display("FAIL same_cycle_pietoni got=%b exp=100", st4); end
        pulse_ready();
        checks++; if (st4 !== 3'b001) begin errors++; $display("FAIL same_cycle_est got=%b exp=001", st4); end
    endtask

    task automatic test_service();
        apply_reset();
        pulse_ready();
        mod_service = 1'b1;
        ready_S = 1'b1;
        step();
        ready_S = 1'b0;
        checks++; if (st4 !== 3'b111 || sc4 !== 1'b1) begin errors++; $display("FAIL svc_enter got=%b/%b exp=111/1", st4, sc4); end
        for (int i = 0; i < 3; i++) begin
            ready_S = (i != 1);
            cerere_pietoni = (i == 1);
            step();
            checks++; if (st4 !== 3'b111 || sc4 !== 1'b0) begin errors++; $display("FAIL svc_hold[%0d] got=%b/%b exp=111/0", i, st4, sc4); end
        end
        ready_S = 1'b0;
        cerere_pietoni = 1'b0;
        mod_service = 1'b0;
        step();
        checks++; if (st4 !== 3'b000 || sc4 !== 1'b1) begin errors++; $display("FAIL svc_exit got=%b/%b exp=000/1", st4, sc4); end
        pulse_ready();
        checks++; if (st4 !== 3'b100) begin errors++; $display("FAIL svc_pending_kept got=%b exp=100", st4); end
        pulse_ready();
        checks++; if (st4 !== 3'b001) begin errors++; $display("FAIL svc_after_ped got=%b exp=001", st4); end
    endtask

    task automatic test_watchdog();
        apply_reset();
        clk_div = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++; if (stw !== 3'b000 || erw !== 1'b0) begin errors++; $display("FAIL wd_pre got=%b/%b exp=000/0", stw, erw); end
        pulse_ready();
        checks++; if (stw !== 3'b001 || erw !== 1'b0) begin errors++; $display("FAIL wd_ready_prio got=%b/%b exp=001/0", stw, erw); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (stw !== 3'b001 || erw !== 1'b0) begin errors++; $display("FAIL wd_cleared got=%b/%b exp=001/0", stw, erw); end
        step();
        checks++; if (stw !== 3'b111 || erw !== 1'b1 || scw !== 1'b1) begin errors++; $display("FAIL wd_fault got=%b/%b/%b exp=111/1/1", stw, erw, scw); end
        for (int i = 0; i < 6; i++) begin
            mod_service = (i < 2);
            ready_S = i[0];
            step();
            checks++; if (stw !== 3'b111 || erw !== 1'b1 || scw !== 1'b0) begin errors++; $display("FAIL wd_sticky[%0d] got=%b/%b/%b exp=111/1/0", i, stw, erw, scw); end
        end
        ready_S = 1'b0;
        mod_service = 1'b0;
        clk_div = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (stw !== 3'b000 || erw !== 1'b0) begin errors++; $display("FAIL wd_rst got=%b/%b exp=000/0", stw, erw); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_rst_pietoni();
        apply_reset();
        cerere_pietoni = 1'b1;
        ready_S = 1'b1;
        step();
        ready_S = 1'b0;
        checks++; if (st4 !== 3'b100) begin errors++; $display("FAIL rstp_enter got=%b exp=100", st4); end
        step();
        #3;
        rst = 1'b1;
        #1;
        cerere_pietoni = 1'b0;
        checks++; if (st4 !== 3'b000 || sc4 !== 1'b0 || er4 !== 1'b0) begin errors++; $display("FAIL rstp_async got=%b/%b/%b exp=000/0/0", st4, sc4, er4); end
        step();
        rst = 1'b0;
        step();
        checks++; if (st4 !== 3'b000 || sc4 !== 1'b0) begin errors++; $display("FAIL rstp_idle got=%b/%b exp=000/0", st4, sc4); end
        pulse_ready();
        checks++; if (st4 !== 3'b001 || sc4 !== 1'b1) begin errors++; $display("FAIL rstp_no_ped got=%b/%b exp=001/1", st4, sc4); end
    endtask

    initial begin
        test_reset();
        test_cycle4();
        test_back_to_back();
        test_pietoni_n3();
        test_same_cycle();
        test_service();
        test_watchdog();
        test_rst_pietoni();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
